// File: rtl/textlcd_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : textlcd_buf_if
// Description : Bundle of host write-port and LCD-pin signals for textlcd_buf.
//               master = host / board side, slave = textlcd_buf controller.
//               AW must match the controller's buffer address width.
// Ports       : wr_en, wr_addr[AW], wr_data[8], clr      (host -> controller)
//               LCD_E, LCD_RS, LCD_RW, LCD_DATA[8],
//               init_done, frame_done                    (controller -> pins)
// Revision    : 1.0 - initial release
// ============================================================================
interface textlcd_buf_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          clr;
  logic          LCD_E;
  logic          LCD_RS;
  logic          LCD_RW;
  logic [7:0]    LCD_DATA;
  logic          init_done;
  logic          frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, clr,
    input  LCD_E, LCD_RS, LCD_RW, LCD_DATA, init_done, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr,
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA, init_done, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/textlcd_buf.sv
`default_nettype none
// ============================================================================
// Module      : textlcd_buf
// Description : HD44780-class character LCD controller, 8-bit write-only.
//               Runs the power-on init sequence, then endlessly refreshes
//               every cell from a COLS x ROWS character buffer that the host
//               writes through a single-cycle port.
// Ports       : clk        - clock, rising edge
//               resetn     - asynchronous reset, active high
//               bus.slave  - wr_en/wr_addr/wr_data/clr in,
//                            LCD_E/LCD_RS/LCD_RW/LCD_DATA/init_done/
//                            frame_done out
// Revision    : 1.0 - initial release
// ============================================================================
module textlcd_buf #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int SLOT        = 30,
  parameter int INIT_WAIT   = 70,
  parameter int CLR_WAIT    = 40,
  parameter int REFRESH_GAP = 40,
  parameter int AW          = $clog2(COLS*ROWS)
) (
  input  wire logic     clk,
  input  wire logic     resetn,
  textlcd_buf_if.slave  bus
);

  localparam int NCELL = COLS * ROWS;
  // Wait phases of zero length still take one cycle.
  localparam int IW_N  = (INIT_WAIT   < 1) ? 1 : INIT_WAIT;
  localparam int CW_N  = (CLR_WAIT    < 1) ? 1 : CLR_WAIT;
  localparam int GAP_N = (REFRESH_GAP < 1) ? 1 : REFRESH_GAP;
  localparam int MAX_A = (IW_N > CW_N) ? IW_N : CW_N;
  localparam int MAX_B = (GAP_N > SLOT) ? GAP_N : SLOT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNTW  = $clog2(CNT_MAX + 1);
  localparam int COLW  = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CNTW-1:0] C_IW_LAST   = CNTW'(IW_N - 1);
  localparam logic [CNTW-1:0] C_CW_LAST   = CNTW'(CW_N - 1);
  localparam logic [CNTW-1:0] C_GAP_LAST  = CNTW'(GAP_N - 1);
  localparam logic [CNTW-1:0] C_SLOT_LAST = CNTW'(SLOT - 1);
  localparam logic [CNTW-1:0] C_E_LAST    = CNTW'(SLOT - 2);
  localparam logic [COLW-1:0] C_COL_LAST  = COLW'(COLS - 1);
  localparam logic            C_ROW_LAST  = 1'(ROWS - 1);
  localparam logic [7:0]      C_FSET_BYTE = (ROWS == 2) ? 8'h38 : 8'h30;

  typedef enum logic [3:0] {
    S_WAIT  = 4'd0,
    S_FSET  = 4'd1,
    S_DISP  = 4'd2,
    S_ENTRY = 4'd3,
    S_CLEAR = 4'd4,
    S_CWAIT = 4'd5,
    S_ADDR  = 4'd6,
    S_CHAR  = 4'd7,
    S_GAP   = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [COLW-1:0] col_q, col_d;
  logic            row_q, row_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;
  logic [NCELL-1:0][7:0] buf_q;

  logic            slot_last;
  logic            byte_d;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_char;
  logic            wr_ok;

  assign slot_last = (cnt_q == C_SLOT_LAST);
  assign wr_ok     = bus.wr_en && (int'(bus.wr_addr) < NCELL);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      S_WAIT:  if (cnt_q == C_IW_LAST) begin state_d = S_FSET;  cnt_d = '0; end
      S_FSET:  if (slot_last)          begin state_d = S_DISP;  cnt_d = '0; end
      S_DISP:  if (slot_last)          begin state_d = S_ENTRY; cnt_d = '0; end
      S_ENTRY: if (slot_last)          begin state_d = S_CLEAR; cnt_d = '0; end
      S_CLEAR: if (slot_last)          begin state_d = S_CWAIT; cnt_d = '0; end
      S_CWAIT: if (cnt_q == C_CW_LAST) begin
        state_d = S_ADDR;
        cnt_d   = '0;
        row_d   = 1'b0;
      end
      S_ADDR: if (slot_last) begin
        state_d = S_CHAR;
        cnt_d   = '0;
        col_d   = '0;
      end
      S_CHAR: if (slot_last) begin
        cnt_d = '0;
        if (col_q == C_COL_LAST) begin
          if (row_q == C_ROW_LAST) begin
            state_d = S_GAP;
          end else begin
            state_d = S_ADDR;
            row_d   = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_GAP: if (cnt_q == C_GAP_LAST) begin
        state_d = S_ADDR;
        cnt_d   = '0;
        row_d   = 1'b0;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: pins are registered, so they are computed from the state
  // the block is about to enter. RS/DATA load only at slot-cycle 0 and hold
  // otherwise, which keeps them stable through the wait phases.
  // --------------------------------------------------------------------------
  assign byte_d  = (state_d == S_FSET) || (state_d == S_DISP) ||
                   (state_d == S_ENTRY) || (state_d == S_CLEAR) ||
                   (state_d == S_ADDR) || (state_d == S_CHAR);
  assign rd_addr = AW'(int'(row_d) * COLS + int'(col_d));

  // A write or clear landing on the same edge as the character fetch is
  // forwarded, so any write made before the fetch edge is displayed.
  always_comb begin
    if (bus.clr) begin
      rd_char = 8'h20;
    end else if (wr_ok && (bus.wr_addr == rd_addr)) begin
      rd_char = bus.wr_data;
    end else begin
      rd_char = buf_q[rd_addr];
    end
  end

  always_comb begin
    e_d          = 1'b0;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    if (byte_d && (cnt_d != '0) && (cnt_d <= C_E_LAST)) begin
      e_d = 1'b1;
    end
    if (byte_d && (cnt_d == '0)) begin
      unique case (state_d)
        S_FSET:  begin rs_d = 1'b0; data_d = C_FSET_BYTE; end
        S_DISP:  begin rs_d = 1'b0; data_d = 8'h0C; end
        S_ENTRY: begin rs_d = 1'b0; data_d = 8'h06; end
        S_CLEAR: begin rs_d = 1'b0; data_d = 8'h01; end
        S_ADDR:  begin rs_d = 1'b0; data_d = row_d ? 8'hC0 : 8'h80; end
        S_CHAR:  begin rs_d = 1'b1; data_d = rd_char; end
        default: begin rs_d = rs_q; data_d = data_q; end
      endcase
    end
    if ((state_q == S_CWAIT) && (state_d == S_ADDR)) begin
      init_done_d = 1'b1;
    end
    if ((state_q != S_GAP) && (state_d == S_GAP)) begin
      frame_done_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      col_q        <= '0;
      row_q        <= 1'b0;
      e_q          <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      e_q          <= e_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Character buffer: clear has priority over a simultaneous write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      buf_q <= {NCELL{8'h20}};
    end else if (bus.clr) begin
      buf_q <= {NCELL{8'h20}};
    end else if (wr_ok) begin
      buf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.LCD_E      = e_q;
  assign bus.LCD_RS     = rs_q;
  assign bus.LCD_RW     = 1'b0;
  assign bus.LCD_DATA   = data_q;
  assign bus.init_done  = init_done_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_textlcd_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_textlcd_buf
// Description : Self-checking bench for textlcd_buf. Two instances run side
//               by side: A is 16x2, B is 16x1. A timeline model derives every
//               pin value from the cycle count since reset release and a
//               mirror of the character buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_textlcd_buf;

  localparam int COLS     = 16;
  localparam int SLOT     = 4;
  localparam int IW       = 10;
  localparam int CW       = 8;
  localparam int RG       = 5;
  localparam int INIT_LEN = IW + 4 * SLOT + CW;          // 34
  localparam int PER_A    = 2 * (COLS + 1) * SLOT + RG;  // 141
  localparam int PER_B    = 1 * (COLS + 1) * SLOT + RG;  // 73

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  textlcd_buf_if #(.AW(5)) bus_a ();
  textlcd_buf_if #(.AW(4)) bus_b ();

  textlcd_buf #(.COLS(COLS), .ROWS(2), .SLOT(SLOT), .INIT_WAIT(IW),
                .CLR_WAIT(CW), .REFRESH_GAP(RG)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a));

  textlcd_buf #(.COLS(COLS), .ROWS(1), .SLOT(SLOT), .INIT_WAIT(IW),
                .CLR_WAIT(CW), .REFRESH_GAP(RG)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int         cyc    [2];
  logic [7:0] mbuf   [2][32];
  logic [7:0] m_data [2];
  logic       m_rs   [2];
  bit         lit_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int k, input int rows);
    case (k)
      0:       return (rows == 2) ? 8'h38 : 8'h30;
      1:       return 8'h0C;
      2:       return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  task automatic apply_wr(input int d, input logic c, input logic en,
                          input int addr, input logic [7:0] data, input int ncell);
    if (c) begin
      for (int i = 0; i < ncell; i++) mbuf[d][i] = 8'h20;
    end else if (en && addr < ncell) begin
      mbuf[d][addr] = data;
    end
  endtask

  // Model advance on each clock edge (inputs are stable around the edge).
  always @(posedge clk) begin
    if (resetn) begin
      for (int d = 0; d < 2; d++) begin
        cyc[d]    = 0;
        m_data[d] = 8'h00;
        m_rs[d]   = 1'b0;
        for (int i = 0; i < 32; i++) mbuf[d][i] = 8'h20;
      end
    end else begin
      cyc[0]++;
      cyc[1]++;
      apply_wr(0, bus_a.clr, bus_a.wr_en, int'(bus_a.wr_addr), bus_a.wr_data, 32);
      apply_wr(1, bus_b.clr, bus_b.wr_en, int'(bus_b.wr_addr), bus_b.wr_data, 16);
    end
  end

  // Expected pins for cycle cyc[d]: position within init or within a frame.
  task automatic model_cmp(input int d, input int rows, input logic e, input logic rs,
                           input logic rw, input logic [7:0] dat,
                           input logic idn, input logic fdn);
    int c, s, fi, fl, slot, row, pos;
    logic xe, xf, xi;
    c  = cyc[d];
    xe = 1'b0;
    xf = 1'b0;
    xi = (c >= INIT_LEN);
    if (c >= IW && c < IW + 4 * SLOT) begin
      s = (c - IW) % SLOT;
      if (s == 0) begin
        m_rs[d]   = 1'b0;
        m_data[d] = init_byte((c - IW) / SLOT, rows);
      end
      xe = (s >= 1 && s <= SLOT - 2);
    end else if (xi) begin
      fl = rows * (COLS + 1) * SLOT;
      fi = (c - INIT_LEN) % (fl + RG);
      if (fi < fl) begin
        slot = fi / SLOT;
        s    = fi % SLOT;
        row  = slot / (COLS + 1);
        pos  = slot % (COLS + 1);
        if (s == 0) begin
          if (pos == 0) begin
            m_rs[d]   = 1'b0;
            m_data[d] = (row == 0) ? 8'h80 : 8'hC0;
          end else begin
            m_rs[d]   = 1'b1;
            m_data[d] = mbuf[d][row * COLS + pos - 1];
          end
        end
        xe = (s >= 1 && s <= SLOT - 2);
      end else begin
        xf = (fi == fl);
      end
    end
    chk($sformatf("E[%0d] cyc%0d", d, c), 32'(e), 32'(xe));
    chk($sformatf("RS[%0d] cyc%0d", d, c), 32'(rs), 32'(m_rs[d]));
    chk($sformatf("RW[%0d] cyc%0d", d, c), 32'(rw), 32'd0);
    chk($sformatf("DATA[%0d] cyc%0d", d, c), 32'(dat), 32'(m_data[d]));
    chk($sformatf("init_done[%0d] cyc%0d", d, c), 32'(idn), 32'(xi));
    chk($sformatf("frame_done[%0d] cyc%0d", d, c), 32'(fdn), 32'(xf));
  endtask

  // Compare process, mid-cycle
  always @(negedge clk) begin
    if (resetn) begin
      chk("rst_E_a", 32'(bus_a.LCD_E), 0);
      chk("rst_RS_a", 32'(bus_a.LCD_RS), 0);
      chk("rst_RW_a", 32'(bus_a.LCD_RW), 0);
      chk("rst_DATA_a", 32'(bus_a.LCD_DATA), 0);
      chk("rst_init_a", 32'(bus_a.init_done), 0);
      chk("rst_frame_a", 32'(bus_a.frame_done), 0);
      chk("rst_E_b", 32'(bus_b.LCD_E), 0);
      chk("rst_DATA_b", 32'(bus_b.LCD_DATA), 0);
    end else begin
      model_cmp(0, 2, bus_a.LCD_E, bus_a.LCD_RS, bus_a.LCD_RW, bus_a.LCD_DATA,
                bus_a.init_done, bus_a.frame_done);
      model_cmp(1, 1, bus_b.LCD_E, bus_b.LCD_RS, bus_b.LCD_RW, bus_b.LCD_DATA,
                bus_b.init_done, bus_b.frame_done);
      // Hand-computed anchors
      if (cyc[0] == 10)  chk("lit_fset_a", 32'(bus_a.LCD_DATA), 32'h38);
      if (cyc[0] == 11)  chk("lit_first_e", 32'(bus_a.LCD_E), 1);
      if (cyc[0] == 22)  chk("lit_clear", 32'(bus_a.LCD_DATA), 32'h01);
      if (cyc[0] == 33)  chk("lit_init_lo", 32'(bus_a.init_done), 0);
      if (cyc[0] == 34)  chk("lit_init_hi", 32'(bus_a.init_done), 1);
      if (cyc[0] == 34)  chk("lit_addr_row0", 32'(bus_a.LCD_DATA), 32'h80);
      if (cyc[0] == 102) chk("lit_addr_row1", 32'(bus_a.LCD_DATA), 32'hC0);
      if (cyc[0] == 170) chk("lit_frame1", 32'(bus_a.frame_done), 1);
      if (cyc[0] == 311) chk("lit_frame2", 32'(bus_a.frame_done), 1);
      if (cyc[1] == 10)  chk("lit_fset_b", 32'(bus_b.LCD_DATA), 32'h30);
      if (cyc[1] == 102) chk("lit_frame1_b", 32'(bus_b.frame_done), 1);
      if (cyc[1] == 175) chk("lit_frame2_b", 32'(bus_b.frame_done), 1);
      if (lit_en) begin
        if (cyc[0] == 38)  chk("lit_h_r0c0", 32'(bus_a.LCD_DATA), 32'h48);
        if (cyc[0] == 38)  chk("lit_h_rs", 32'(bus_a.LCD_RS), 1);
        if (cyc[0] == 42)  chk("lit_r0c1", 32'(bus_a.LCD_DATA), 32'h20);
        if (cyc[0] == 110) chk("lit_i_r1c1", 32'(bus_a.LCD_DATA), 32'h49);
        if (cyc[0] == 179) chk("lit_old_val", 32'(bus_a.LCD_DATA), 32'h48);
        if (cyc[0] == 320) chk("lit_new_val", 32'(bus_a.LCD_DATA), 32'h41);
        if (cyc[0] == 473) chk("lit_clr_wins", 32'(bus_a.LCD_DATA), 32'h20);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle_inputs();
    bus_a.wr_en = 1'b0; bus_a.clr = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.wr_en = 1'b0; bus_b.clr = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int addr, input logic [7:0] data, input logic c);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'(addr);
    bus_a.wr_data = data;
    bus_a.clr     = c;
    step();
    idle_inputs();
  endtask

  task automatic wait_until_a(input int target);
    int guard;
    guard = 0;
    while (cyc[0] < target && guard < 2000) begin
      step();
      guard++;
    end
    chk("wait_until_bound", 32'(cyc[0] >= target), 1);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.wr_en   = ($urandom_range(3) == 0);
      bus_a.wr_addr = 5'($urandom_range(31));
      bus_a.wr_data = 8'($urandom_range(8'h7E, 8'h21));
      bus_a.clr     = ($urandom_range(199) == 0);
      bus_b.wr_en   = ($urandom_range(3) == 0);
      bus_b.wr_addr = 4'($urandom_range(15));
      bus_b.wr_data = 8'($urandom_range(8'h7E, 8'h21));
      bus_b.clr     = ($urandom_range(199) == 0);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    int guard;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;

    // Writes during init
    step(); step(); step();
    wr_a(0, 8'h48, 1'b0);
    wr_a(17, 8'h49, 1'b0);

    // Overwrite cell 0 after its slot in frame 2
    wait_until_a(INIT_LEN + PER_A + 10);
    wr_a(0, 8'h41, 1'b0);

    // Fill, then clear together with a write: clear wins
    wait_until_a(330);
    for (int i = 0; i < 8; i++) wr_a(i, 8'h41, 1'b0);
    wr_a(3, 8'h5A, 1'b1);
    wait_until_a(480);

    rand_cycles(3000);

    // Asynchronous reset in the middle of a character slot
    guard = 0;
    while (!(bus_a.LCD_RS === 1'b1 && bus_a.LCD_E === 1'b1) && guard < 400) begin
      step();
      guard++;
    end
    chk("find_char_slot", 32'(guard < 400), 1);
    lit_en = 1'b0;
    resetn = 1'b1;
    #1;
    chk("async_rst_E", 32'(bus_a.LCD_E), 0);
    chk("async_rst_DATA", 32'(bus_a.LCD_DATA), 0);
    chk("async_rst_RS", 32'(bus_a.LCD_RS), 0);
    chk("async_rst_init", 32'(bus_a.init_done), 0);
    chk("async_rst_E_b", 32'(bus_b.LCD_E), 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (300) step();
    rand_cycles(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
